reg_file_mp: RTL and testbench

Parametrised multi-read-port register file for the RV32IM pipeline, the successor to the fixed 32x32 two-read-port file. It adds a configurable data width, depth and read-port count, plus same-cycle write-to-read bypass and a per-register pending scoreboard for in-flight producers. It also adds a hardware-sequenced clear that sweeps the array while signalling busy. It sits between decode (read and reserve) and writeback (write).

---
 rtl/rf_pkg.sv | 10 +
 rtl/reg_file_mp_if.sv | 19 +
 rtl/rf_scoreboard.sv | 33 +++
 rtl/reg_file_mp.sv | 53 +++++
 tb/tb_reg_file_mp.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared types, defaults and packing helper for the multi-port register file
package rf_pkg;
  typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_t;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREAD  = 2;
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: decode/writeback-facing bus of the multi-port register file
interface reg_file_mp_if import rf_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREAD  = RF_NREAD
);
  logic                    WRITE;
  logic [ADDR_W-1:0]       ADDRW;
  logic [DATA_W-1:0]       IN;
  logic [NREAD*ADDR_W-1:0] ADDR;
  logic [NREAD*DATA_W-1:0] OUT;
  logic [NREAD-1:0]        PENDING;
  logic                    RESERVE;
  logic [ADDR_W-1:0]       ADDRV;
  logic                    CLEAR;
  logic                    CLR_BUSY;
  modport master (output WRITE, ADDRW, IN, ADDR, RESERVE, ADDRV, CLEAR, input OUT, PENDING, CLR_BUSY);
  modport slave  (input WRITE, ADDRW, IN, ADDR, RESERVE, ADDRV, CLEAR, output OUT, PENDING, CLR_BUSY);
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits with reserve/write/sweep priority and read lookups
module rf_scoreboard import rf_pkg::*; #(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NREAD    = RF_NREAD,
  parameter int ZERO_REG = 1
)(
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic                    swp_en,
  input  logic [ADDR_W-1:0]       swp_addr,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD-1:0]        rd_pend
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] pend;
  logic rsv_ok;
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  // reserve is applied after the write clear so a new producer wins
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) pend <= '0;
    else if (swp_en) pend[swp_addr] <= 1'b0;
    else begin
      if (wr_en) pend[wr_addr] <= 1'b0;
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
    end
  for (genvar k = 0; k < NREAD; k++) begin : g_lk
    assign rd_pend[k] = pend[rd_addr[slice_lo(k, ADDR_W) +: ADDR_W]];
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with bypass, pending scoreboard
// and a hardware clear sweep
module reg_file_mp import rf_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NREAD    = RF_NREAD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
)(
  input logic          CLK,
  input logic          RESET,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  rf_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle, wr_ok, rsv_ok;
  logic [NREAD-1:0]  sb_pend;
  assign idle         = state == RF_IDLE;
  assign wr_ok        = idle && bus.WRITE && !(ZERO_REG != 0 && bus.ADDRW == '0);
  assign rsv_ok       = idle && bus.RESERVE;
  assign bus.CLR_BUSY = !idle;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= idle ? (bus.CLEAR ? RF_SWEEP : RF_IDLE) : (cnt == '1 ? RF_IDLE : RF_SWEEP);
      cnt   <= idle ? '0 : cnt + 1'b1;
    end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (!idle) mem[cnt] <= '0;
    else if (wr_ok) mem[bus.ADDRW] <= bus.IN;
  rf_scoreboard #(.ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(ZERO_REG)) u_sb (
    .CLK(CLK), .RESET(RESET),
    .wr_en(wr_ok), .wr_addr(bus.ADDRW),
    .rsv_en(rsv_ok), .rsv_addr(bus.ADDRV),
    .swp_en(!idle), .swp_addr(cnt),
    .rd_addr(bus.ADDR), .rd_pend(sb_pend)
  );
  // wr_ok already excludes the sweep and the zero register, so bypass inherits both
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zr, byp;
    assign ra = bus.ADDR[slice_lo(k, ADDR_W) +: ADDR_W];
    assign zr = ZERO_REG != 0 && ra == '0;
    assign byp = BYPASS != 0 && wr_ok && bus.ADDRW == ra;
    assign bus.OUT[slice_lo(k, DATA_W) +: DATA_W] = zr ? '0 : byp ? bus.IN : mem[ra];
    assign bus.PENDING[k] = !zr && !byp && sb_pend[k];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: bypass and non-bypass instances driven in lockstep and checked against
// an array-based model of the register file
module tb_reg_file_mp;
  import rf_pkg::*;
  logic CLK = 0, RESET = 1;
  logic wr = 0, rs = 0, clr = 0;
  logic [4:0] wa = 0, rv = 0;
  logic [31:0] din = 0;
  logic [9:0] ra = 0;
  int n_cmp = 0, n_fail = 0;
  bit chk_on = 0;
  logic [31:0] m_mem [32];
  bit m_pend [32];
  int m_sweep;
  reg_file_mp_if b1 ();
  reg_file_mp_if b0 ();
  assign b1.WRITE = wr;  assign b0.WRITE = wr;
  assign b1.ADDRW = wa;  assign b0.ADDRW = wa;
  assign b1.IN = din;    assign b0.IN = din;
  assign b1.ADDR = ra;   assign b0.ADDR = ra;
  assign b1.RESERVE = rs; assign b0.RESERVE = rs;
  assign b1.ADDRV = rv;  assign b0.ADDRV = rv;
  assign b1.CLEAR = clr; assign b0.CLEAR = clr;
  reg_file_mp #(.BYPASS(1)) u_byp (.CLK(CLK), .RESET(RESET), .bus(b1.slave));
  reg_file_mp #(.BYPASS(0)) u_nob (.CLK(CLK), .RESET(RESET), .bus(b0.slave));
  always #5 CLK = ~CLK;
  // m_sweep is the next entry to clear, -1 when no sweep is running
  always @(posedge CLK or negedge RESET)
    if (!RESET) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] <= 0;
        m_pend[i] <= 0;
      end
      m_sweep <= -1;
    end else if (m_sweep >= 0) begin
      m_mem[m_sweep] <= 0;
      m_pend[m_sweep] <= 0;
      m_sweep <= (m_sweep == 31) ? -1 : m_sweep + 1;
    end else begin
      if (clr) m_sweep <= 0;
      if (wr && wa != 0) begin
        m_mem[wa] <= din;
        m_pend[wa] <= 0;
      end
      if (rs && rv != 0) m_pend[rv] <= 1;
    end
  function automatic logic [31:0] e_out(input int a, input bit byp);
    if (a == 0) return 0;
    if (byp && m_sweep < 0 && wr && int'(wa) == a) return din;
    return m_mem[a];
  endfunction
  function automatic logic e_pend(input int a, input bit byp);
    if (a == 0) return 0;
    if (byp && m_sweep < 0 && wr && int'(wa) == a) return 0;
    return m_pend[a];
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge CLK)
    if (chk_on) begin
      int a;
      for (int k = 0; k < 2; k++) begin
        a = int'(ra[k*5 +: 5]);
        chk($sformatf("byp out%0d r%0d", k, a), b1.OUT[k*32 +: 32], e_out(a, 1));
        chk($sformatf("nob out%0d r%0d", k, a), b0.OUT[k*32 +: 32], e_out(a, 0));
        chk($sformatf("byp pend%0d r%0d", k, a), 32'(b1.PENDING[k]), 32'(e_pend(a, 1)));
        chk($sformatf("nob pend%0d r%0d", k, a), 32'(b0.PENDING[k]), 32'(e_pend(a, 0)));
      end
      chk("byp busy", 32'(b1.CLR_BUSY), 32'(m_sweep >= 0));
      chk("nob busy", 32'(b0.CLR_BUSY), 32'(m_sweep >= 0));
    end
  task automatic cyc(input bit w, input int aw, input logic [31:0] d, input bit r, input int av,
                     input bit c, input int r0, input int r1);
    @(posedge CLK);
    #1;
    wr = w; wa = 5'(aw); din = d; rs = r; rv = 5'(av); clr = c;
    ra = {5'(r1), 5'(r0)};
  endtask
  initial begin
    int busy_n;
    ra = {5'd9, 5'd5};
    #1 RESET = 0;
    #12;
    chk("rst out0", b1.OUT[31:0], 0);
    chk("rst out1", b1.OUT[63:32], 0);
    chk("rst pend", 32'(b1.PENDING), 0);
    chk("rst busy", 32'(b1.CLR_BUSY), 0);
    @(posedge CLK); #1 RESET = 1; chk_on = 1;
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
    cyc(0, 0, 0, 0, 0, 0, 5, 5); #2;
    chk("r5 byp p0", b1.OUT[31:0], 32'hDEADBEEF);
    chk("r5 byp p1", b1.OUT[63:32], 32'hDEADBEEF);
    chk("r5 nob p0", b0.OUT[31:0], 32'hDEADBEEF);
    chk("r5 pend", 32'(b1.PENDING), 0);
    chk("model r5", m_mem[5], 32'hDEADBEEF);
    cyc(1, 7, 32'h12345678, 0, 0, 0, 7, 5); #2;
    chk("r7 bypass", b1.OUT[31:0], 32'h12345678);
    chk("r7 no bypass old", b0.OUT[31:0], 0);
    cyc(0, 0, 0, 0, 0, 0, 7, 7); #2;
    chk("r7 no bypass new", b0.OUT[31:0], 32'h12345678);
    cyc(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0); #2;
    chk("r0 write bypass", b1.OUT[31:0], 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("r0 out", b1.OUT[31:0], 0);
    chk("r0 pend", 32'(b1.PENDING), 0);
    cyc(0, 0, 0, 1, 3, 0, 3, 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 3); #2;
    chk("r3 reserved byp", 32'(b1.PENDING), 3);
    chk("r3 reserved nob", 32'(b0.PENDING), 3);
    cyc(1, 3, 32'hA5, 0, 0, 0, 3, 3); #2;
    chk("r3 write pend byp", 32'(b1.PENDING), 0);
    chk("r3 write pend nob", 32'(b0.PENDING), 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 3); #2;
    chk("r3 after write pend", 32'(b0.PENDING), 0);
    chk("r3 after write out", b0.OUT[31:0], 32'hA5);
    cyc(1, 3, 32'h77, 1, 3, 0, 3, 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 3); #2;
    chk("r3 wr+rsv out", b1.OUT[63:32], 32'h77);
    chk("r3 wr+rsv pend", 32'(b1.PENDING), 3);
    chk("model r3 pend", 32'(m_pend[3]), 1);
    repeat (400)
      cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 63) == 0, $urandom_range(0, 7), $urandom_range(0, 7));
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1 RESET = 0;
    @(posedge CLK); #1 RESET = 1;
    for (int i = 1; i < 32; i++) cyc(1, i, 32'h1000_0000 + i, 0, 0, 0, i, 1);
    cyc(0, 0, 0, 1, 9, 0, 9, 1);
    cyc(0, 0, 0, 0, 0, 1, 9, 31);
    busy_n = 0;
    for (int t = 0; t < 100; t++) begin
      cyc($urandom_range(0, 1), $urandom_range(1, 31), $urandom, $urandom_range(0, 1),
          $urandom_range(1, 31), 0, $urandom_range(0, 31), $urandom_range(0, 31));
      #2;
      if (b1.CLR_BUSY) busy_n++;
      else begin
        wr = 0; rs = 0;
        break;
      end
    end
    chk("sweep length", busy_n, 32);
    for (int a = 0; a < 32; a += 2) begin
      cyc(0, 0, 0, 0, 0, 0, a, a + 1); #2;
      chk($sformatf("swept r%0d", a), b1.OUT[31:0], 0);
      chk($sformatf("swept r%0d", a + 1), b1.OUT[63:32], 0);
      chk($sformatf("swept pend r%0d", a), 32'(b1.PENDING), 0);
    end
    for (int i = 1; i < 32; i++) cyc(1, i, 32'h2000_0000 + i, 0, 0, 0, 20, 21);
    cyc(0, 0, 0, 0, 0, 1, 20, 21);
    repeat (10) cyc(0, 0, 0, 0, 0, 0, 20, 21);
    @(posedge CLK); #1 RESET = 0;
    #1;
    chk("mid-sweep reset busy", 32'(b1.CLR_BUSY), 0);
    chk("mid-sweep reset r20", b1.OUT[31:0], 0);
    chk("mid-sweep reset r21", b0.OUT[63:32], 0);
    #2 RESET = 1;
    cyc(1, 1, 32'h11, 0, 0, 0, 1, 2);
    cyc(1, 2, 32'h22, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 1, 1, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 2); #2;
    chk("fresh sweep busy", 32'(b1.CLR_BUSY), 1);
    chk("fresh sweep r1 held", b1.OUT[31:0], 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 1, 2); #2;
    chk("fresh sweep r1 still", b1.OUT[31:0], 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 1, 2); #2;
    chk("fresh sweep r1 cleared", b1.OUT[31:0], 0);
    chk("fresh sweep r2 held", b1.OUT[63:32], 32'h22);
    repeat (40) cyc(0, 0, 0, 0, 0, 0, 1, 2);
    @(posedge CLK);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
